// File: rtl/rca_seq_pkg.sv
// Shared types and defaults for the sequential ripple-carry add/sub controller.
package rca_seq_pkg;

    localparam int RCA_SEQ_WIDTH = 32;
    localparam int RCA_SEQ_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca.sv
// Ripple-carry adder of SIZE bits, one full-adder cell per bit.
module rca #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    logic [SIZE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SIZE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SIZE];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: one CHUNK-wide RCA reused over WIDTH/CHUNK cycles, LS slice first.
// Optional subtract support is enabled with the RCA_SEQ_SUB_EN macro.
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = RCA_SEQ_WIDTH,
    parameter int CHUNK = RCA_SEQ_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("rca_seq_ctrl: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             sub_eff;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

`ifdef RCA_SEQ_SUB_EN
    assign sub_eff = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready depends only on registered state (and rst_n), never on the partner's valid.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    assign slice_a = a_r[idx*CHUNK +: CHUNK];
    assign slice_b = b_r[idx*CHUNK +: CHUNK];

    rca #(.SIZE(CHUNK)) u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        // Subtraction is a + ~b + 1: invert here, the +1 rides in on carry_r.
                        b_r      <= sub_eff ? ~b : b;
                        carry_r  <= sub_eff;
                        idx      <= '0;
                        result_r <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result_r[idx*CHUNK +: CHUNK] <= slice_sum;
                    carry_r <= slice_cout;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result    = result_r;
    assign carry_out = carry_r;
    assign overflow  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (result_r[WIDTH-1] != a_r[WIDTH-1]);

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed and random bench for rca_seq_ctrl (WIDTH=32, CHUNK=8) with an expected-result queue.
module tb_rca_seq_ctrl;

    localparam int W = 34;  // {carry, overflow, result[31:0]}

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;

    logic [W-1:0] exp_q[$];
    int           passed;
    int           total;

    rca_seq_ctrl #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Reference behaviour: two's-complement add, or a-b when subtraction is built in.
    function automatic logic [W-1:0] model(input logic [31:0] ai, input logic [31:0] bi, input logic si);
        logic [31:0] be;
        logic        c0;
        logic [32:0] full;
        logic        ovf;
`ifdef RCA_SEQ_SUB_EN
        be = si ? ~bi : bi;
        c0 = si;
`else
        be = bi;
        c0 = 1'b0;
        if (si) be = bi;
`endif
        full = {1'b0, ai} + {1'b0, be} + {32'd0, c0};
        ovf  = (ai[31] == be[31]) && (full[31] != ai[31]);
        return {full[32], ovf, full[31:0]};
    endfunction

    // Driver: one full operation; hold > 0 stalls DONE with new operands on the input.
    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                          input int hold, input logic [W-1:0] expv, input string tag);
        int lat;
        logic [W-1:0] front;
        a = ai; b = bi; sub = si; in_valid = 1'b1;
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        step();
        exp_q.push_back(expv);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, W'(lat), W'(4));
        front = exp_q[0];
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 32'h1234_5678; b = 32'h0101_0101; sub = 1'b0;
            for (int i = 0; i < hold; i++) begin
                chk({tag, "_hold_result"}, {carry_out, overflow, result}, front);
                chk({tag, "_hold_in_ready"}, W'(in_ready), W'(0));
                chk({tag, "_hold_out_valid"}, W'(out_valid), W'(1));
                step();
            end
        end
        out_ready = 1'b1;
        if (exp_q.size() > 0) begin
            front = exp_q.pop_front();
            chk({tag, "_result"}, {carry_out, overflow, result}, front);
        end else begin
            chk({tag, "_queue_empty"}, W'(0), W'(1));
        end
        step();
        out_ready = 1'b0;
        chk({tag, "_out_valid_low"}, W'(out_valid), W'(0));
        chk({tag, "_idle_in_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        passed = 0; total = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;

        step(); step();
        chk("reset_in_ready", W'(in_ready), W'(0));
        chk("reset_outputs", {out_valid, carry_out, overflow, result}, W'(0));
        rst_n = 1'b1;
        #1;
        chk("reset_release_in_ready", W'(in_ready), W'(1));

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, {2'b00, 32'h0000_0100}, "ff_plus_1");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, {2'b10, 32'h0000_0000}, "carry_chain");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, {2'b01, 32'h8000_0000}, "signed_ovf");
`ifdef RCA_SEQ_SUB_EN
        run_op(32'd5, 32'd7, 1'b1, 0, {2'b00, 32'hFFFF_FFFE}, "sub_5_7");
`else
        run_op(32'd5, 32'd7, 1'b1, 0, {2'b00, 32'h0000_000C}, "sub_5_7");
`endif

        // Backpressure: new operands on the bus while DONE stalls; they must not sneak in.
        run_op(32'h0000_1000, 32'h0000_0234, 1'b0, 3, {2'b00, 32'h0000_1234}, "backpressure");
        run_op(32'h1234_5678, 32'h0101_0101, 1'b0, 0, {2'b00, 32'h1335_5779}, "after_stall");

        // Reset in the middle of RUN drops the operation.
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", W'(in_ready), W'(0));
        step();
        rst_n = 1'b1;
        #1;
        chk("midrun_rst_out_valid", W'(out_valid), W'(0));
        chk("midrun_rst_result", {carry_out, overflow, result}, W'(0));
        chk("midrun_rst_in_ready_back", W'(in_ready), W'(1));
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, {2'b11, 32'h0000_0000}, "post_reset");

        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, $urandom_range(0, 2), model(ra, rb, rs), "random");
        end

        chk("queue_drained", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Multi-cycle adder controller that time-shares one narrow ripple-carry adder to produce a full-width sum. The operation runs over WIDTH/CHUNK clock cycles, one CHUNK-wide slice per cycle, least-significant slice first. Operands enter and results leave on valid/ready handshakes. It sits beside the integer datapath as an area-reduced add/sub unit for multi-cycle execute paths where a full-width carry chain is not wanted.

## Interface
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: width of the shared adder slice. WIDTH % CHUNK must be 0. N = WIDTH/CHUNK.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, synchronous, active-low. Sampled on the rising edge of clk.
- in_valid  in  1: operands are valid.
- in_ready  out  1: block can accept operands.
- a, b  in  WIDTH: operands.
- sub  in  1: 1 selects a−b. Only used when the macro is defined.
- out_valid  out  1: result is valid.
- out_ready  in  1: consumer accepts the result.
- result  out  WIDTH: sum or difference.
- carry_out  out  1: carry out of bit WIDTH−1. For sub, 1 means no borrow.
- overflow  out  1: signed overflow of the operation.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a into a_r. Latch b into b_r, inverted if sub is effective. Set carry_r to the effective sub value. Set idx = 0. Clear result_r. Go to RUN.
- RUN, each cycle:
  - The shared adder computes a_r[idx slice] + b_r[idx slice] + carry_r.
  - The sum is written into the idx slice of result_r. The slice carry goes to carry_r. idx increments.
  - The cycle with idx == N−1 goes to DONE.
- DONE:
  - out_valid = 1. result, carry_out and overflow are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0, so in_valid is ignored.
- overflow = (a_r[WIDTH−1] == b_r[WIDTH−1]) && (result_r[WIDTH−1] != a_r[WIDTH−1]). b_r is the effective, possibly inverted, operand.
- in_ready = rst_n && (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state.
- idx width is clog2(N), with a minimum of 1 bit. It never wraps inside RUN.
- With N == 1: RUN lasts one cycle.

## Timing
- Reset:
  - rst_n low at an edge forces state IDLE, idx = 0, carry_r = 0, result = 0, carry_out = 0, overflow = 0, out_valid = 0.
  - in_ready is 0 while rst_n is low.
  - Reset has priority over every handshake. Reset during RUN or DONE discards the operation with no output.
- Latency:
  - Operands accepted at edge E0. Slices are written at edges E1..EN. out_valid is high from the cycle after EN.
  - That is N cycles of latency; 4 for the defaults.
- Throughput: one operation per N+2 cycles when out_ready is held high (accept, N RUN cycles, DONE).
- Backpressure: DONE holds indefinitely while out_ready = 0. Outputs do not change.
- Operands a, b and sub only need to be valid in the accept cycle. Later changes have no effect.
- result is meaningful only while out_valid = 1. During RUN, result shows partially filled data. Consumers must not sample it then.

## Configuration
- RCA_SEQ_SUB_EN defined:
  - sub is honoured. b is inverted at accept and carry_r starts at 1, so the output is two's-complement a−b.
- RCA_SEQ_SUB_EN undefined:
  - sub is ignored, not connected to logic. Every operation is a+b with carry_r starting at 0.
  - Port list is unchanged.

## Structure
- Package rca_seq_pkg holds:
  - the FSM state typedef (IDLE/RUN/DONE, 2-bit);
  - default constants RCA_SEQ_WIDTH = 32 and RCA_SEQ_CHUNK = 8.
- One sub-module: the existing RCA ripple-carry module, instantiated once with SIZE = CHUNK.
  - Inputs: the selected slices and carry_r. Outputs: the slice sum and slice carry.
- Slice selection uses indexed part-selects on idx. No other sub-modules.
- Add an elaboration-time check for WIDTH % CHUNK == 0.

## Test plan
All scenarios use WIDTH = 32, CHUNK = 8.
- a=0x000000FF, b=0x00000001, sub=0: result=0x00000100, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFFFFFF, b=0x00000001: result=0x00000000, carry_out=1, overflow=0. Checks carry propagation through all four slices.
- a=0x7FFFFFFF, b=0x00000001: result=0x80000000, carry_out=0, overflow=1.
- With RCA_SEQ_SUB_EN, a=5, b=7, sub=1: result=0xFFFFFFFE, carry_out=0, overflow=0. Without the macro, the same stimulus gives result=0x0000000C.
- out_ready held 0 for 3 cycles in DONE, with in_valid=1 and new operands applied: result stays stable, in_ready=0, and the new operands are not accepted until one cycle after out_ready goes high.
- rst_n low for one edge after 2 RUN cycles: in the next cycle out_valid=0, result=0 and in_ready=1. A following operation completes correctly.
